// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the BRAM controller state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe and alignment check for one AHB address phase.
module ahb_strb_gen
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [LW-1:0] addr_lo,
  input  logic [2:0]    hsize,
  output logic [NB-1:0] strb,
  output logic          misalign
);

  // Lane mask shifted to the addressed byte; oversize is judged by the caller
  always_comb begin
    strb     = '0;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        strb     = NB'(1'b1) << addr_lo;
        misalign = 1'b0;
      end
      HSIZE_HALF: begin
        strb     = NB'(2'b11) << addr_lo;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = NB'(4'hF) << addr_lo;
        misalign = |addr_lo[1:0];
      end
      HSIZE_DWORD: begin
        strb     = '1;
        misalign = |addr_lo;
      end
      default: begin
        strb     = '0;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of one synchronous BRAM port, with ERROR responses.
// Optional write protection of the low WP_WORDS words: define AHB_BRAM_WPROT_EN.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int WP_WORDS = 256,
  localparam int NB      = DATA_W / 8,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic              hresp,
  output logic              bram_en,
  output logic [NB-1:0]     bram_we,
  output logic [IDX_W-1:0]  bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int LW     = $clog2(NB);
  localparam int IDXF_W = ADDR_W - LW;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("ahb_bram_ctrl: DATA_W must be 32 or 64");
  end
  if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
    $error("ahb_bram_ctrl: RD_LAT must be 1 or 2");
  end
  if (WP_WORDS < 0) begin : g_bad_wp_words
    $error("ahb_bram_ctrl: WP_WORDS must not be negative");
  end

  state_e             state_r;
  state_e             state_n_s;
  logic [IDX_W-1:0]   idx_r;
  logic [NB-1:0]      strb_r;
  logic [1:0]         cnt_r;
  logic               rd_done_r;
  logic [DATA_W-1:0]  hrdata_hold_r;

  logic               trans_valid_s;
  logic               accept_s;
  logic               err_s;
  logic               misalign_s;
  logic               oversize_s;
  logic               range_s;
  logic               wprot_s;
  logic               last_rd_s;
  logic [NB-1:0]      strb_s;
  logic [IDXF_W-1:0]  idx_full_s;

  ahb_strb_gen #(.DATA_W(DATA_W)) u_strb_gen (
    .addr_lo  (haddr[LW-1:0]),
    .hsize    (hsize),
    .strb     (strb_s),
    .misalign (misalign_s)
  );

  assign idx_full_s = haddr[ADDR_W-1:LW];
  assign oversize_s = (hsize > 3'(LW));
  assign range_s    = (idx_full_s >= IDXF_W'(DEPTH));
`ifdef AHB_BRAM_WPROT_EN
  assign wprot_s    = hwrite && (idx_full_s < IDXF_W'(WP_WORDS));
`else
  assign wprot_s    = 1'b0;
`endif
  assign err_s      = misalign_s || oversize_s || range_s || wprot_s;
  assign accept_s   = hsel && trans_valid_s && hready;
  assign last_rd_s  = (state_r == ST_RD) && (cnt_r == 2'(RD_LAT));

  // Only NONSEQ/SEQ start a transfer
  always_comb begin
    trans_valid_s = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY:  trans_valid_s = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_valid_s = 1'b1;
      default:                   trans_valid_s = 1'b0;
    endcase
  end

  // Next state: WR and ERR2 end with hready high, so they may accept like IDLE
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE, ST_WR, ST_ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_n_s = ST_ERR1;
          end else if (hwrite) begin
            state_n_s = ST_WR;
          end else begin
            state_n_s = ST_RD;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (last_rd_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_RD;
        end
      end
      ST_ERR1: state_n_s = ST_ERR2;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Bus and RAM outputs decoded from registered state
  always_comb begin
    hready   = 1'b1;
    hresp    = 1'b0;
    bram_en  = 1'b0;
    bram_we  = '0;
    bram_din = '0;
    case (state_r)
      ST_WR: begin
        bram_en  = 1'b1;
        bram_we  = strb_r;
        bram_din = hwdata;
      end
      ST_RD: begin
        bram_en = 1'b1;
        hready  = 1'b0;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      ST_IDLE: hready = 1'b1;
      default: hready = 1'b1;
    endcase
  end

  assign bram_addr = idx_r;

  // RAM data is valid in the completing cycle; afterwards the latched copy is shown
  always_comb begin
    if (rd_done_r) begin
      hrdata = bram_dout;
    end else begin
      hrdata = hrdata_hold_r;
    end
  end

  // State, captured address phase, latency counter and read-data hold
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      strb_r        <= '0;
      cnt_r         <= 2'd0;
      rd_done_r     <= 1'b0;
      hrdata_hold_r <= '0;
    end else begin
      state_r <= state_n_s;
      if (accept_s && !err_s) begin
        idx_r  <= idx_full_s[IDX_W-1:0];
        strb_r <= strb_s;
      end
      cnt_r     <= (state_r == ST_RD) ? cnt_r + 2'd1 : 2'd1;
      rd_done_r <= last_rd_s;
      if (rd_done_r) begin
        hrdata_hold_r <= bram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench: DUT 0 is RD_LAT=1/DEPTH=1024, DUT 1 is RD_LAT=2/DEPTH=64.
module tb_ahb_bram_ctrl;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [2:0] SZ_B   = 3'd0;
  localparam logic [2:0] SZ_H   = 3'd1;
  localparam logic [2:0] SZ_W   = 3'd2;

  logic        clk = 1'b0;
  logic        hreset_n;
  logic        ram_init;
  logic        hsel_a   [2];
  logic [31:0] haddr_a  [2];
  logic [1:0]  htrans_a [2];
  logic        hwrite_a [2];
  logic [2:0]  hsize_a  [2];
  logic [31:0] hwdata_a [2];
  logic [31:0] hrdata_a [2];
  logic        hready_a [2];
  logic        hresp_a  [2];
  logic        en_a     [2];
  logic [3:0]  we_a     [2];
  logic [31:0] addr_a   [2];
  logic [31:0] din_a    [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int DEP = (g == 0) ? 1024 : 64;
    localparam int WPW = (g == 0) ? 256 : 0;
    localparam int AW  = $clog2(DEP);

    logic [AW-1:0] addr_l;
    logic [31:0]   dout_l;
    logic [31:0]   mem [DEP];
    logic [31:0]   pipe [2];

    ahb_bram_ctrl #(.DATA_W(32), .DEPTH(DEP), .ADDR_W(32), .RD_LAT(LAT), .WP_WORDS(WPW)) u_dut (
      .hclk      (clk),
      .hreset_n  (hreset_n),
      .hsel      (hsel_a[g]),
      .haddr     (haddr_a[g]),
      .htrans    (htrans_a[g]),
      .hwrite    (hwrite_a[g]),
      .hsize     (hsize_a[g]),
      .hwdata    (hwdata_a[g]),
      .hrdata    (hrdata_a[g]),
      .hready    (hready_a[g]),
      .hresp     (hresp_a[g]),
      .bram_en   (en_a[g]),
      .bram_we   (we_a[g]),
      .bram_addr (addr_l),
      .bram_din  (din_a[g]),
      .bram_dout (dout_l)
    );

    assign addr_a[g] = 32'(addr_l);
    assign dout_l    = pipe[LAT-1];

    // Synchronous RAM model with LAT-cycle read pipeline
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < DEP; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      end else if (en_a[g]) begin
        for (int b = 0; b < 4; b++)
          if (we_a[g][b]) mem[addr_l][8*b +: 8] <= din_a[g][8*b +: 8];
        pipe[0] <= mem[addr_l];
      end
      pipe[1] <= pipe[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aph(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a);
    hsel_a[d]   = sel;
    htrans_a[d] = tr;
    hwrite_a[d] = wr;
    hsize_a[d]  = sz;
    haddr_a[d]  = a;
  endtask

  task automatic idle(input int d);
    aph(d, 1'b0, T_IDLE, 1'b0, SZ_B, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    hreset_n = 1'b0;
    ram_init = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle(d);
      hwdata_a[d] = 32'h0;
    end
    tick();
    tick();
    chk("rst_hready", 32'(hready_a[0]), 32'h1);
    chk("rst_hresp",  32'(hresp_a[0]),  32'h0);
    chk("rst_hrdata", hrdata_a[0],      32'h0);
    chk("rst_en",     32'(en_a[0]),     32'h0);
    chk("rst_we",     32'(we_a[0]),     32'h0);
    chk("rst_addr",   addr_a[0],        32'h0);
    chk("rst_din",    din_a[0],         32'h0);
    ram_init = 1'b0;
    hreset_n = 1'b1;

    // Word write then read back at 0x40
    tick();
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h40);
    settle();
    chk("wr_aph_ready", 32'(hready_a[0]), 32'h1);
    tick();
    hwdata_a[0] = 32'hDEAD_BEEF;
    aph(0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40);
    settle();
    chk("wr_we",    32'(we_a[0]),     32'hF);
    chk("wr_addr",  addr_a[0],        32'h10);
    chk("wr_din",   din_a[0],         32'hDEAD_BEEF);
    chk("wr_ready", 32'(hready_a[0]), 32'h1);
    tick();
    idle(0);
    hwdata_a[0] = 32'h0;
    settle();
    chk("rd_wait",  32'(hready_a[0]), 32'h0);
    chk("rd_en",    32'(en_a[0]),     32'h1);
    chk("rd_we",    32'(we_a[0]),     32'h0);
    tick();
    settle();
    chk("rd_ready", 32'(hready_a[0]), 32'h1);
    chk("rd_resp",  32'(hresp_a[0]),  32'h0);
    chk("rd_data",  hrdata_a[0],      32'hDEAD_BEEF);
    tick();
    settle();
    chk("rd_hold",  hrdata_a[0],      32'hDEAD_BEEF);

    // Byte write at 0x43, halfword write at 0x40, word read: AA AD 12 34
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_B, 32'h43);
    tick();
    hwdata_a[0] = 32'hAAAA_AAAA;
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_H, 32'h40);
    settle();
    chk("byte_we", 32'(we_a[0]), 32'h8);
    tick();
    hwdata_a[0] = 32'h1234_1234;
    aph(0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40);
    settle();
    chk("half_we", 32'(we_a[0]), 32'h3);
    tick();
    idle(0);
    settle();
    chk("merge_wait", 32'(hready_a[0]), 32'h0);
    tick();
    settle();
    chk("merge_data", hrdata_a[0], 32'hAAAD_1234);

    // Misaligned halfword write, then out-of-range word write issued during ERR2
    tick();
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_H, 32'h41);
    tick();
    hwdata_a[0] = 32'hFFFF_FFFF;
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h1000);
    settle();
    chk("mis_e1_ready", 32'(hready_a[0]), 32'h0);
    chk("mis_e1_resp",  32'(hresp_a[0]),  32'h1);
    chk("mis_e1_we",    32'(we_a[0]),     32'h0);
    tick();
    settle();
    chk("mis_e2_ready", 32'(hready_a[0]), 32'h1);
    chk("mis_e2_resp",  32'(hresp_a[0]),  32'h1);
    tick();
    idle(0);
    settle();
    chk("oor_e1_ready", 32'(hready_a[0]), 32'h0);
    chk("oor_e1_resp",  32'(hresp_a[0]),  32'h1);
    chk("oor_e1_we",    32'(we_a[0]),     32'h0);
    tick();
    settle();
    chk("oor_e2_ready", 32'(hready_a[0]), 32'h1);
    chk("oor_e2_resp",  32'(hresp_a[0]),  32'h1);
    chk("oor_e2_en",    32'(en_a[0]),     32'h0);
    tick();
    aph(0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40);
    tick();
    idle(0);
    tick();
    settle();
    chk("err_ram_intact", hrdata_a[0], 32'hAAAD_1234);

    // Asynchronous reset during the RD cycle, then a clean read
    tick();
    aph(0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40);
    tick();
    idle(0);
    settle();
    chk("arst_pre_wait", 32'(hready_a[0]), 32'h0);
    hreset_n = 1'b0;
    #1;
    chk("arst_ready",  32'(hready_a[0]), 32'h1);
    chk("arst_en",     32'(en_a[0]),     32'h0);
    chk("arst_hrdata", hrdata_a[0],      32'h0);
    #1;
    hreset_n = 1'b1;
    tick();
    aph(0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40);
    tick();
    idle(0);
    settle();
    chk("arst_rd_wait", 32'(hready_a[0]), 32'h0);
    tick();
    settle();
    chk("arst_rd_data", hrdata_a[0],     32'hAAAD_1234);
    chk("arst_rd_resp", 32'(hresp_a[0]), 32'h0);

    // Write at index 0xFF (protected when enabled) then at index 0x100
    tick();
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h3FC);
    tick();
    hwdata_a[0] = 32'h1111_1111;
    aph(0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h400);
    settle();
`ifdef AHB_BRAM_WPROT_EN
    chk("wp_lo_ready", 32'(hready_a[0]), 32'h0);
    chk("wp_lo_resp",  32'(hresp_a[0]),  32'h1);
    chk("wp_lo_we",    32'(we_a[0]),     32'h0);
    tick();
    settle();
    chk("wp_lo_e2_resp", 32'(hresp_a[0]), 32'h1);
`else
    chk("wp_lo_we",    32'(we_a[0]),    32'hF);
    chk("wp_lo_addr",  addr_a[0],       32'hFF);
    chk("wp_lo_resp",  32'(hresp_a[0]), 32'h0);
`endif
    tick();
    hwdata_a[0] = 32'h2222_2222;
    aph(0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h3FC);
    settle();
    chk("wp_hi_we",   32'(we_a[0]),    32'hF);
    chk("wp_hi_addr", addr_a[0],       32'h100);
    chk("wp_hi_resp", 32'(hresp_a[0]), 32'h0);
    tick();
    idle(0);
    tick();
    settle();
`ifdef AHB_BRAM_WPROT_EN
    chk("wp_lo_data", hrdata_a[0], 32'hA500_00FF);
`else
    chk("wp_lo_data", hrdata_a[0], 32'h1111_1111);
`endif

    // RD_LAT=2: back-to-back reads at 0x0 and 0x4
    tick();
    aph(1, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h0);
    tick();
    aph(1, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h4);
    settle();
    chk("l2_a_w1", 32'(hready_a[1]), 32'h0);
    tick();
    settle();
    chk("l2_a_w2", 32'(hready_a[1]), 32'h0);
    tick();
    settle();
    chk("l2_a_ready", 32'(hready_a[1]), 32'h1);
    chk("l2_a_data",  hrdata_a[1],      32'hA500_0000);
    tick();
    idle(1);
    settle();
    chk("l2_b_w1",   32'(hready_a[1]), 32'h0);
    chk("l2_b_addr", addr_a[1],        32'h1);
    tick();
    settle();
    chk("l2_b_w2", 32'(hready_a[1]), 32'h0);
    tick();
    settle();
    chk("l2_b_ready", 32'(hready_a[1]), 32'h1);
    chk("l2_b_data",  hrdata_a[1],      32'hA500_0001);
    chk("l2_b_resp",  32'(hresp_a[1]),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
